// File: rtl/pacman_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pacman_pkg
//  Description : Shared types and colour constants for the Pac-Man sprite.
//  Revision    : 1.0 - initial release
// ============================================================================
package pacman_pkg;

    // Heading of the sprite; the encoding is visible on debug taps.
    typedef enum logic [1:0] {
        RIGHT = 2'd0,
        LEFT  = 2'd1,
        UP    = 2'd2,
        DOWN  = 2'd3
    } dir_t;

    // Mouth animation phase.
    typedef enum logic [1:0] {
        OPEN   = 2'd0,
        HALF   = 2'd1,
        CLOSED = 2'd2,
        HALF_B = 2'd3
    } mouth_t;

    // Colours in RRRGGGBB.
    localparam logic [7:0] YELLOW = 8'b111_111_00;
    localparam logic [7:0] BLACK  = 8'h00;

endpackage : pacman_pkg
`default_nettype wire

// File: rtl/pacman_shape.sv
`default_nettype none
// ============================================================================
//  Module      : pacman_shape
//  Description : Combinational 16x16 Pac-Man mask (disk minus mouth wedge)
//                for one local coordinate, heading and mouth phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module pacman_shape
    import pacman_pkg::*;
(
    input  logic [3:0] lx,
    input  logic [3:0] ly,
    input  logic [1:0] dir,
    input  logic [1:0] mouth,
    output logic       mask
);

    logic signed [5:0] w_dx;
    logic signed [5:0] w_dy;
    logic [3:0]        w_adx;
    logic [3:0]        w_ady;
    logic [8:0]        w_r2;
    logic              w_disk;
    logic signed [5:0] w_f;
    logic signed [5:0] w_l;
    logic [3:0]        w_fmag;
    logic [3:0]        w_alat;
    logic              w_fpos;
    logic              w_wedge;

    // Centre the 0..15 grid on the sprite middle: odd values -15..15.
    assign w_dx = $signed({1'b0, lx, 1'b0}) - 6'sd15;
    assign w_dy = $signed({1'b0, ly, 1'b0}) - 6'sd15;

    // Squares from magnitudes keep the multipliers small and unsigned.
    always_comb begin
        w_adx  = w_dx[5] ? 4'(-w_dx) : w_dx[3:0];
        w_ady  = w_dy[5] ? 4'(-w_dy) : w_dy[3:0];
        w_r2   = {1'b0, {4'b0, w_adx} * {4'b0, w_adx}}
               + {1'b0, {4'b0, w_ady} * {4'b0, w_ady}};
        w_disk = (w_r2 <= 9'd256);
    end

    // Rotate into forward/lateral axes of the current heading.
    always_comb begin
        w_f = w_dx;
        w_l = w_dy;
        case (dir)
            LEFT:    begin w_f = -w_dx; w_l = w_dy; end
            UP:      begin w_f = -w_dy; w_l = w_dx; end
            DOWN:    begin w_f = w_dy;  w_l = w_dx; end
            default: begin w_f = w_dx;  w_l = w_dy; end
        endcase
    end

    // Wedge opening narrows with the mouth phase and vanishes when closed.
    always_comb begin
        w_fpos  = !w_f[5] && (w_f != 6'sd0);
        w_fmag  = w_f[3:0];
        w_alat  = w_l[5] ? 4'(-w_l) : w_l[3:0];
        w_wedge = 1'b0;
        case (mouth)
            OPEN:        w_wedge = w_fpos && (w_alat <= w_fmag);
            HALF, HALF_B: w_wedge = w_fpos && ({w_alat, 1'b0} <= {1'b0, w_fmag});
            default:     w_wedge = 1'b0;
        endcase
        mask = w_disk && !w_wedge;
    end

endmodule : pacman_shape
`default_nettype wire

// File: rtl/pacman_sprite.sv
`default_nettype none
// ============================================================================
//  Module      : pacman_sprite
//  Description : Pixel-stage Pac-Man renderer. Owns position, heading and
//                mouth animation; emits registered RRRGGGBB per pixel strobe.
//  Revision    : 1.0 - initial release
// ============================================================================
module pacman_sprite
    import pacman_pkg::*;
#(
    parameter int SIZE        = 16,
    parameter int STEP        = 2,
    parameter int X_INIT      = 312,
    parameter int Y_INIT      = 232,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int ANIM_FRAMES = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_pix_stb,
    input  logic [9:0] i_x,
    input  logic [8:0] i_y,
    input  logic       i_animate,
    input  logic       i_up,
    input  logic       i_down,
    input  logic       i_left,
    input  logic       i_right,
    output logic [2:0] o_r,
    output logic [2:0] o_g,
    output logic [1:0] o_b,
    output logic       o_hit,
    output logic       o_blocked
);

    localparam int         c_FCNT_W    = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
    localparam logic [9:0] c_X_MAX     = 10'(H_ACTIVE - SIZE);
    localparam logic [8:0] c_Y_MAX     = 9'(V_ACTIVE - SIZE);
    localparam logic [9:0] c_STEP_X    = 10'(STEP);
    localparam logic [8:0] c_STEP_Y    = 9'(STEP);
    localparam logic [c_FCNT_W-1:0] c_FCNT_LAST = c_FCNT_W'(ANIM_FRAMES - 1);

    logic [9:0]          r_px;
    logic [8:0]          r_py;
    dir_t                r_dir;
    dir_t                r_pend;
    mouth_t              r_mouth;
    logic [c_FCNT_W-1:0] r_fcnt;

    dir_t                w_pend_nxt;
    logic [9:0]          w_nx;
    logic [8:0]          w_ny;
    logic                w_blocked;
    mouth_t              w_mouth_nxt;
    logic [c_FCNT_W-1:0] w_fcnt_nxt;
    logic [1:0]          w_shape_mouth;
    logic                w_in_x;
    logic                w_in_y;
    logic [9:0]          w_xoff;
    logic [8:0]          w_yoff;
    logic                w_mask;
    logic                w_hit;

    // Button priority: up > down > left > right; no button keeps the request.
    always_comb begin
        w_pend_nxt = r_pend;
        if (i_up)         w_pend_nxt = UP;
        else if (i_down)  w_pend_nxt = DOWN;
        else if (i_left)  w_pend_nxt = LEFT;
        else if (i_right) w_pend_nxt = RIGHT;
    end

    // Candidate position one step along the pending heading, clamped without wrap.
    always_comb begin
        w_nx = r_px;
        w_ny = r_py;
        case (r_pend)
            RIGHT: w_nx = (r_px >= c_X_MAX - c_STEP_X) ? c_X_MAX : r_px + c_STEP_X;
            LEFT:  w_nx = (r_px < c_STEP_X) ? 10'd0 : r_px - c_STEP_X;
            UP:    w_ny = (r_py < c_STEP_Y) ? 9'd0 : r_py - c_STEP_Y;
            DOWN:  w_ny = (r_py >= c_Y_MAX - c_STEP_Y) ? c_Y_MAX : r_py + c_STEP_Y;
            default: ;
        endcase
        w_blocked = (w_nx == r_px) && (w_ny == r_py);
    end

    // Position, heading and request registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_px      <= 10'(X_INIT);
            r_py      <= 9'(Y_INIT);
            r_dir     <= RIGHT;
            r_pend    <= RIGHT;
            o_blocked <= 1'b0;
        end else begin
            r_pend <= w_pend_nxt;
            if (i_animate) begin
                r_dir     <= r_pend;
                r_px      <= w_nx;
                r_py      <= w_ny;
                o_blocked <= w_blocked;
            end
        end
    end

    // Mouth FSM state register (phase plus frame counter).
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mouth <= OPEN;
            r_fcnt  <= '0;
        end else begin
            r_mouth <= w_mouth_nxt;
            r_fcnt  <= w_fcnt_nxt;
        end
    end

    // Mouth FSM next state: only frames that actually moved advance the animation.
    always_comb begin
        w_mouth_nxt = r_mouth;
        w_fcnt_nxt  = r_fcnt;
        if (i_animate && !w_blocked) begin
            if (r_fcnt == c_FCNT_LAST) begin
                w_fcnt_nxt = '0;
                case (r_mouth)
                    OPEN:    w_mouth_nxt = HALF;
                    HALF:    w_mouth_nxt = CLOSED;
                    CLOSED:  w_mouth_nxt = HALF_B;
                    default: w_mouth_nxt = OPEN;
                endcase
            end else begin
                w_fcnt_nxt = r_fcnt + 1'b1;
            end
        end
    end

    // Mouth FSM output: phase presented to the shape generator.
    always_comb begin
        w_shape_mouth = r_mouth;
    end

    // Bounding-box test and local coordinates against the pre-update position.
    always_comb begin
        w_xoff = i_x - r_px;
        w_yoff = i_y - r_py;
        w_in_x = ({1'b0, i_x} >= {1'b0, r_px}) && ({1'b0, i_x} < {1'b0, r_px} + 11'(SIZE));
        w_in_y = ({1'b0, i_y} >= {1'b0, r_py}) && ({1'b0, i_y} < {1'b0, r_py} + 10'(SIZE));
        w_hit  = w_in_x && w_in_y && w_mask;
    end

    pacman_shape u_shape (
        .lx    (w_xoff[3:0]),
        .ly    (w_yoff[3:0]),
        .dir   (r_dir),
        .mouth (w_shape_mouth),
        .mask  (w_mask)
    );

    // Colour output register, updated once per pixel strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            {o_r, o_g, o_b} <= BLACK;
            o_hit           <= 1'b0;
        end else if (i_pix_stb) begin
            {o_r, o_g, o_b} <= w_hit ? YELLOW : BLACK;
            o_hit           <= w_hit;
        end
    end

endmodule : pacman_sprite
`default_nettype wire

// File: tb/tb_pacman_sprite.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pacman_sprite
//  Description : Directed self-checking bench for pacman_sprite.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pacman_sprite;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_pix_stb = 1'b0;
    logic [9:0] i_x = '0;
    logic [8:0] i_y = '0;
    logic       i_animate = 1'b0;
    logic       i_up = 1'b0, i_down = 1'b0, i_left = 1'b0, i_right = 1'b0;
    logic [2:0] o_r;
    logic [2:0] o_g;
    logic [1:0] o_b;
    logic       o_hit;
    logic       o_blocked;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [8:0] PIX_YEL = 9'b111_111_00_1;
    localparam logic [8:0] PIX_BLK = 9'b000_000_00_0;

    pacman_sprite dut (
        .clk       (clk),
        .rst       (rst),
        .i_pix_stb (i_pix_stb),
        .i_x       (i_x),
        .i_y       (i_y),
        .i_animate (i_animate),
        .i_up      (i_up),
        .i_down    (i_down),
        .i_left    (i_left),
        .i_right   (i_right),
        .o_r       (o_r),
        .o_g       (o_g),
        .o_b       (o_b),
        .o_hit     (o_hit),
        .o_blocked (o_blocked)
    );

    always #5 clk = ~clk;

    // One clock; inputs set before the call are sampled at this edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [9:0] x, input logic [8:0] y, input logic anim);
        i_x = x; i_y = y; i_pix_stb = 1'b1; i_animate = anim;
        tick();
        i_pix_stb = 1'b0; i_animate = 1'b0;
    endtask

    task automatic animate(input int n);
        for (int k = 0; k < n; k++) begin
            i_animate = 1'b1;
            tick();
            i_animate = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; i_pix_stb = 1'b1; i_animate = 1'b1;
        tick(); tick();
        rst = 1'b0; i_pix_stb = 1'b0; i_animate = 1'b0;
        n_checks++; if (dut.r_px !== 10'd312) begin n_fail++; $display("FAIL reset_px got %0d expected 312", dut.r_px); end
        n_checks++; if (dut.r_py !== 9'd232) begin n_fail++; $display("FAIL reset_py got %0d expected 232", dut.r_py); end
        n_checks++; if ({o_r, o_g, o_b, o_hit, o_blocked} !== 10'd0) begin n_fail++; $display("FAIL reset_outputs got %b expected 0", {o_r, o_g, o_b, o_hit, o_blocked}); end
        n_checks++; if (dut.r_mouth !== 2'd0 || dut.r_fcnt !== 3'd0) begin n_fail++; $display("FAIL reset_mouth got %0d/%0d expected 0/0", dut.r_mouth, dut.r_fcnt); end
        n_checks++; if (dut.r_dir !== 2'd0) begin n_fail++; $display("FAIL reset_dir got %0d expected 0", dut.r_dir); end
    endtask

    task automatic test_pixel();
        strobe(10'd319, 9'd239, 1'b0);
        n_checks++; if ({o_r, o_g, o_b, o_hit} !== PIX_YEL) begin n_fail++; $display("FAIL pix_centre got %b expected %b", {o_r, o_g, o_b, o_hit}, PIX_YEL); end
        // Strobe low: a mouth pixel must not reach the outputs.
        i_x = 10'd324; i_y = 9'd240;
        tick();
        n_checks++; if ({o_r, o_g, o_b, o_hit} !== PIX_YEL) begin n_fail++; $display("FAIL pix_hold got %b expected %b", {o_r, o_g, o_b, o_hit}, PIX_YEL); end
        strobe(10'd324, 9'd240, 1'b0);
        n_checks++; if ({o_r, o_g, o_b, o_hit} !== PIX_BLK) begin n_fail++; $display("FAIL pix_mouth_open got %b expected %b", {o_r, o_g, o_b, o_hit}, PIX_BLK); end
        strobe(10'd319, 9'd239, 1'b0);
        strobe(10'd311, 9'd239, 1'b0);
        n_checks++; if ({o_r, o_g, o_b, o_hit} !== PIX_BLK) begin n_fail++; $display("FAIL pix_left_edge got %b expected %b", {o_r, o_g, o_b, o_hit}, PIX_BLK); end
    endtask

    task automatic test_move();
        animate(1);
        n_checks++; if (dut.r_px !== 10'd314 || dut.r_py !== 9'd232 || o_blocked !== 1'b0) begin n_fail++; $display("FAIL move_right got %0d,%0d,%b expected 314,232,0", dut.r_px, dut.r_py, o_blocked); end
        i_left = 1'b1; tick(); i_left = 1'b0;
        animate(1);
        n_checks++; if (dut.r_px !== 10'd312 || dut.r_dir !== 2'd1) begin n_fail++; $display("FAIL move_left got %0d dir %0d expected 312 dir 1", dut.r_px, dut.r_dir); end
        i_up = 1'b1; i_right = 1'b1; tick(); i_up = 1'b0; i_right = 1'b0;
        animate(1);
        n_checks++; if (dut.r_py !== 9'd230 || dut.r_dir !== 2'd2 || dut.r_fcnt !== 3'd3) begin n_fail++; $display("FAIL move_priority got py %0d dir %0d fcnt %0d expected 230 2 3", dut.r_py, dut.r_dir, dut.r_fcnt); end
    endtask

    task automatic test_heading_up();
        // Heading UP, OPEN: sprite at (312,230).
        strobe(10'd320, 9'd233, 1'b0);
        n_checks++; if ({o_r, o_g, o_b, o_hit} !== PIX_BLK) begin n_fail++; $display("FAIL up_mouth got %b expected %b", {o_r, o_g, o_b, o_hit}, PIX_BLK); end
        strobe(10'd324, 9'd238, 1'b0);
        n_checks++; if ({o_r, o_g, o_b, o_hit} !== PIX_YEL) begin n_fail++; $display("FAIL up_side got %b expected %b", {o_r, o_g, o_b, o_hit}, PIX_YEL); end
    endtask

    task automatic test_clamp_top();
        i_up = 1'b1;
        animate(116);
        n_checks++; if (dut.r_py !== 9'd0 || o_blocked !== 1'b1) begin n_fail++; $display("FAIL clamp_first got py %0d blk %b expected 0 1", dut.r_py, o_blocked); end
        n_checks++; if (dut.r_mouth !== 2'd2 || dut.r_fcnt !== 3'd6) begin n_fail++; $display("FAIL clamp_anim_first got %0d/%0d expected 2/6", dut.r_mouth, dut.r_fcnt); end
        animate(84);
        i_up = 1'b0;
        n_checks++; if (dut.r_py !== 9'd0 || o_blocked !== 1'b1 || dut.r_px !== 10'd312) begin n_fail++; $display("FAIL clamp_end got %0d,%0d blk %b expected 312,0,1", dut.r_px, dut.r_py, o_blocked); end
        n_checks++; if (dut.r_mouth !== 2'd2 || dut.r_fcnt !== 3'd6) begin n_fail++; $display("FAIL clamp_frozen got %0d/%0d expected 2/6", dut.r_mouth, dut.r_fcnt); end
    endtask

    task automatic test_mouth();
        rst = 1'b1; tick(); rst = 1'b0;
        animate(7);
        n_checks++; if (dut.r_mouth !== 2'd0 || dut.r_fcnt !== 3'd7 || dut.r_px !== 10'd326) begin n_fail++; $display("FAIL mouth_seven got %0d/%0d px %0d expected 0/7 326", dut.r_mouth, dut.r_fcnt, dut.r_px); end
        animate(1);
        n_checks++; if (dut.r_mouth !== 2'd1 || dut.r_fcnt !== 3'd0) begin n_fail++; $display("FAIL mouth_half got %0d/%0d expected 1/0", dut.r_mouth, dut.r_fcnt); end
        strobe(10'd340, 9'd240, 1'b0);
        n_checks++; if ({o_r, o_g, o_b, o_hit} !== PIX_BLK) begin n_fail++; $display("FAIL pix_half got %b expected %b", {o_r, o_g, o_b, o_hit}, PIX_BLK); end
        animate(8);
        n_checks++; if (dut.r_mouth !== 2'd2 || dut.r_px !== 10'd344) begin n_fail++; $display("FAIL mouth_closed got %0d px %0d expected 2 344", dut.r_mouth, dut.r_px); end
        strobe(10'd356, 9'd240, 1'b0);
        n_checks++; if ({o_r, o_g, o_b, o_hit} !== PIX_YEL) begin n_fail++; $display("FAIL pix_closed got %b expected %b", {o_r, o_g, o_b, o_hit}, PIX_YEL); end
    endtask

    task automatic test_back_to_back();
        strobe(10'd344, 9'd239, 1'b1);
        n_checks++; if ({o_r, o_g, o_b, o_hit} !== PIX_YEL) begin n_fail++; $display("FAIL same_clk_old_pos got %b expected %b", {o_r, o_g, o_b, o_hit}, PIX_YEL); end
        n_checks++; if (dut.r_px !== 10'd346 || dut.r_fcnt !== 3'd1) begin n_fail++; $display("FAIL same_clk_move got px %0d fcnt %0d expected 346 1", dut.r_px, dut.r_fcnt); end
        strobe(10'd344, 9'd239, 1'b0);
        n_checks++; if ({o_r, o_g, o_b, o_hit} !== PIX_BLK) begin n_fail++; $display("FAIL new_pos_edge got %b expected %b", {o_r, o_g, o_b, o_hit}, PIX_BLK); end
    endtask

    task automatic test_reset_mid();
        strobe(10'd353, 9'd239, 1'b0);
        n_checks++; if ({o_r, o_g, o_b, o_hit} !== PIX_YEL) begin n_fail++; $display("FAIL pre_reset got %b expected %b", {o_r, o_g, o_b, o_hit}, PIX_YEL); end
        rst = 1'b1; tick(); rst = 1'b0;
        n_checks++; if ({o_r, o_g, o_b, o_hit, o_blocked} !== 10'd0 || dut.r_px !== 10'd312) begin n_fail++; $display("FAIL mid_reset got %b px %0d expected 0 312", {o_r, o_g, o_b, o_hit, o_blocked}, dut.r_px); end
        strobe(10'd319, 9'd239, 1'b0);
        n_checks++; if ({o_r, o_g, o_b, o_hit} !== PIX_YEL) begin n_fail++; $display("FAIL post_reset got %b expected %b", {o_r, o_g, o_b, o_hit}, PIX_YEL); end
    endtask

    initial begin
        test_reset();
        test_pixel();
        test_move();
        test_heading_up();
        test_clamp_top();
        test_mouth();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pacman_sprite
`default_nettype wire

// File: doc/pacman_sprite.md
Name: pacman_sprite

Overview:
- Pixel-stage renderer directly downstream of the 640x480 VGA timing generator.
- Consumes the current pixel coordinate and a once-per-frame animate pulse.
- Owns the Pac-Man sprite state: position, heading and mouth animation.
- Produces registered 8-bit RRRGGGBB colour for the VGA pins, one pixel strobe after the coordinate.

Parameters:
SIZE, 16, sprite side in pixels (power of two, 16 fixed for the mask maths)
STEP, 2, pixels moved per animate pulse
X_INIT, 312, reset top-left x
Y_INIT, 232, reset top-left y
H_ACTIVE, 640, visible width
V_ACTIVE, 480, visible height
ANIM_FRAMES, 8, moving frames per mouth phase

Ports:
clk  in  1  50 MHz system clock
rst  in  1  synchronous active-high reset
i_pix_stb  in  1  25 MHz pixel enable, one clk wide
i_x  in  10  current pixel x (0-1023)
i_y  in  9  current pixel y (0-511)
i_animate  in  1  one-clk pulse at end of active frame
i_up, i_down, i_left, i_right  in  1 each  direction buttons, already synchronised
o_r  out  3  red
o_g  out  3  green
o_b  out  2  blue
o_hit  out  1  current output pixel is sprite body
o_blocked  out  1  last move was clamped at an edge

Behaviour:
- Single clock domain.
  - All state updates on rising clk.
  - rst is synchronous and active-high, with priority over everything.
- Reset values:
  - px=X_INIT, py=Y_INIT.
  - dir=RIGHT, pend=RIGHT.
  - mouth=OPEN, fcnt=0.
  - o_r/o_g/o_b/o_hit/o_blocked=0.
- Direction request (every clk): if any button is high, pend takes the highest-priority asserted button, in order up > down > left > right. With no buttons, pend holds.
- Frame update (i_animate=1):
  - dir <= pend.
  - Compute the candidate position one STEP along pend.
  - Clamp x to 0..H_ACTIVE-SIZE (624) and y to 0..V_ACTIVE-SIZE (464). Underflow must clamp to 0, not wrap.
  - o_blocked <= 1 if the clamped result equals the old position, else 0.
- Mouth FSM:
  - Cycle is OPEN -> HALF -> CLOSED -> HALF_B -> OPEN.
  - fcnt increments on each animate pulse where o_blocked's new value is 0.
  - When fcnt reaches ANIM_FRAMES-1 and increments, fcnt <= 0 and the state advances.
  - Blocked frames freeze both fcnt and mouth.
- Pixel path (only when i_pix_stb=1; otherwise outputs hold):
  - Inside test: px <= i_x < px+SIZE and py <= i_y < py+SIZE.
  - Local coordinates lx=i_x-px, ly=i_y-py (4 bits each).
  - dx=2*lx-15 and dy=2*ly-15, signed 6-bit.
  - Disk: dx*dx + dy*dy <= 256.
  - Heading-rotated axes: f is the forward axis, l the lateral axis.
    - RIGHT: f=dx, l=dy.
    - LEFT: f=-dx, l=dy.
    - UP: f=-dy, l=dx.
    - DOWN: f=dy, l=dx.
  - Mouth wedge requires f>0, plus:
    - OPEN: |l| <= f.
    - HALF/HALF_B: 2|l| <= f.
    - CLOSED: never.
  - hit = inside & disk & ~wedge.
  - Registered result:
    - hit=1: o_r=7, o_g=7, o_b=0, o_hit=1.
    - hit=0: o_r=0, o_g=0, o_b=0, o_hit=0.
  - Latency is exactly one pixel strobe (the output is valid from the clk after the strobe).
- Simultaneous i_pix_stb and i_animate: the pixel uses the pre-update px/py/dir/mouth.
- Reset mid-frame: all outputs go to 0 on the next clk. The next frame renders at X_INIT/Y_INIT.
- Coordinates outside the visible area: rendered as black through the inside test. No blanking is done here; the timing generator owns blanking.

Decomposition:
- pacman_pkg holds:
  - dir_t {RIGHT=0, LEFT=1, UP=2, DOWN=3}.
  - mouth_t {OPEN, HALF, CLOSED, HALF_B}.
  - Colour constants YELLOW=8'b111_111_00 and BLACK=8'h00.
- One combinational sub-module, pacman_shape: inputs lx, ly, dir, mouth; output mask bit (disk and ~wedge).
- pacman_sprite keeps the position, pending direction, FSM and output registers.

Test Plan:
- Reset: assert rst for 2 clk -> px=312, py=232, o_r/o_g/o_b/o_hit/o_blocked=0, mouth=OPEN.
- No buttons, one i_animate -> px=314, py=232, o_blocked=0. Then i_left pulse plus i_animate -> dir=LEFT, px=312.
- Press i_up and i_right together, then i_animate -> dir=UP, py=230. Hold UP for 200 frames -> py=0 and o_blocked=1; mouth and fcnt stay frozen.
- Pixel at (x=319, y=239), i.e. lx=7, ly=7, with a strobe -> o_r=7, o_g=7, o_b=0, o_hit=1 on the next clk. At (324, 240), i.e. lx=12, ly=8, heading RIGHT and OPEN -> black, o_hit=0.
- Eight unblocked animate pulses -> mouth=HALF. Eight more -> CLOSED; the pixel at lx=12, ly=8 is now yellow.
- i_pix_stb and i_animate in the same clk at lx=0 of the old px -> the output reflects the old position. rst mid-frame -> outputs are 0 on the next clk.
